// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if -- instruction-fetch handshake bundle.
//   imem_req_*  : fetch request to instruction memory (valid/ready, address)
//   imem_resp_* : instruction memory response (valid, data)
//   inst_*      : buffered instruction towards decode (valid/ready, data, pc)
// Modports: master = fetch controller side, slave = memory/decode side.
interface fetch_ctrl_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- single-outstanding instruction fetch controller.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc_curr/pc_next : current PC in, combinational next PC out
//   bus (master)    : imem request/response and decode instruction buffer
//   redirect_valid/redirect_addr, trap_valid : control-flow redirects
//   fetch_misalign  : registered one-cycle pulse on a misaligned redirect
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_curr,
    output logic [31:0]  pc_next,
    fetch_ctrl_if.master bus,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_addr,
    input  logic         trap_valid,
    output logic         fetch_misalign
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_data_q, inst_pc_q;
    logic        misalign_q, misalign_d;
    logic        capture;
    logic        req_valid;
    logic        redirect;
    logic        addr_misaligned;
    logic [31:0] target;

    assign redirect        = (trap_valid || redirect_valid) && (state_q != IDLE);
    assign addr_misaligned = (redirect_addr[1:0] != 2'b00);
    assign target          = (trap_valid || addr_misaligned) ? TRAP_VEC : redirect_addr;

    always_comb begin
        state_d    = state_q;
        pc_next    = pc_curr;
        req_valid  = 1'b0;
        capture    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req_valid = 1'b1;
                if (redirect)
                    // An accepted request still owes a response that must be dropped.
                    state_d = bus.imem_req_ready ? DRAIN : REQ;
                else if (bus.imem_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (redirect)
                    state_d = bus.imem_resp_valid ? REQ : DRAIN;
                else if (bus.imem_resp_valid) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect)
                    state_d = REQ;
                else if (bus.inst_ready) begin
                    pc_next = pc_curr + 32'd4;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // A redirect here does not change anything: the stale response
                // is still owed, so leave as soon as it arrives.
                if (bus.imem_resp_valid)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_next    = target;
            misalign_d = !trap_valid && addr_misaligned;
        end

        if (rst)
            pc_next = RESET_ADDR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
            if (capture) begin
                inst_data_q <= bus.imem_resp_data;
                inst_pc_q   <= pc_curr;
            end
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not only after the edge.
    assign bus.imem_req_valid = req_valid && !rst;
    assign bus.imem_req_addr  = pc_curr;
    assign bus.inst_valid     = (state_q == HOLD) && !rst;
    assign bus.inst_data      = rst ? '0 : inst_data_q;
    assign bus.inst_pc        = rst ? '0 : inst_pc_q;
    assign fetch_misalign     = misalign_q && !rst;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000, SHALL be the PC value driven on pc_next while rst is high.
REQ-002 Parameter TRAP_VEC, default 32'h00000100, SHALL be the target for trap_valid and misaligned redirects.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_curr  input  32  current PC from the pc register.
REQ-006 pc_next  output  32  next PC to the pc register; combinational.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  32  fetch address; SHALL equal pc_curr.
REQ-009 imem_req_ready  input  1  instruction memory accepts request.
REQ-010 imem_resp_valid  input  1  response data valid.
REQ-011 imem_resp_data  input  32  fetched instruction word.
REQ-012 inst_valid  output  1  buffered instruction valid to decode.
REQ-013 inst_data  output  32  buffered instruction word.
REQ-014 inst_pc  output  32  address of the buffered instruction.
REQ-015 inst_ready  input  1  decode accepts the instruction.
REQ-016 redirect_valid  input  1  branch/jump redirect request.
REQ-017 redirect_addr  input  32  redirect target.
REQ-018 trap_valid  input  1  exception; redirect to TRAP_VEC.
REQ-019 fetch_misalign  output  1  registered one-cycle pulse on misaligned redirect.

Function
REQ-020 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; at most one memory request SHALL be outstanding.
REQ-021 IDLE: all valids low, pc_next=pc_curr; unconditional transition to REQ next cycle.
REQ-022 REQ: imem_req_valid=1; on imem_req_ready -> WAIT; else stay.
REQ-023 WAIT: on imem_resp_valid capture imem_resp_data into inst_data and pc_curr into inst_pc -> HOLD.
REQ-024 HOLD: inst_valid=1; on inst_ready, pc_next=pc_curr+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0) -> REQ.
REQ-025 Outside REQ-024 and redirects, pc_next SHALL equal pc_curr (PC holds).
REQ-026 Redirect event = trap_valid or redirect_valid in any state except IDLE; trap_valid SHALL take priority.
REQ-027 Redirect target: TRAP_VEC if trap_valid; else TRAP_VEC if redirect_addr[1:0]!=0 (fetch_misalign pulses next cycle); else redirect_addr.
REQ-028 On a redirect event pc_next SHALL equal the target that cycle; a redirect overrides the +4 of REQ-024 even when inst_ready is high.
REQ-029 Redirect next state: REQ without ready -> REQ; REQ with ready -> DRAIN; WAIT without resp -> DRAIN; WAIT with resp -> REQ (response discarded); HOLD -> REQ (buffer discarded); DRAIN -> DRAIN.
REQ-030 inst_valid SHALL be low from the cycle after a redirect event until a post-redirect response is captured.
REQ-031 DRAIN: imem_req_valid=0; on imem_resp_valid discard data -> REQ.
REQ-032 imem_req_valid, once high in REQ, SHALL not drop before imem_req_ready unless a redirect occurs.
REQ-033 inst_data and inst_pc SHALL remain stable while inst_valid is high and inst_ready is low.
REQ-034 imem_resp_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-035 While rst is high: pc_next=RESET_ADDR; imem_req_valid, inst_valid, fetch_misalign=0; inst_data, inst_pc=0; state IDLE.
REQ-036 rst asserted in any state SHALL abort the operation in flight; any late response SHALL be ignored (IDLE/REQ do not capture).

Verification
REQ-037 Reset release, ready=1, 1-cycle response latency -> request at 0x0 two cycles after reset, inst_valid with inst_pc=0x0, then request at 0x4 after inst_ready.
REQ-038 inst_ready held low 5 cycles in HOLD -> inst_valid, inst_data, inst_pc stable, pc_next=pc_curr, no new request.
REQ-039 redirect_valid, redirect_addr=0x40 in WAIT, response 3 cycles later -> DRAIN, response discarded, next request addr 0x40.
REQ-040 trap_valid and redirect_valid (addr 0x80) in the same cycle -> pc_next=0x100, next fetch at 0x100.
REQ-041 redirect_addr=0x42 -> fetch_misalign one-cycle pulse, next fetch at 0x100.
REQ-042 pc_curr=0xFFFFFFFC, inst accepted -> pc_next=0x00000000; rst mid-WAIT -> pc_next=RESET_ADDR, all valids low.
